count_sequencer: RTL

//  Controller for the 4-bit count / 7-segment display datapath. A prescaler produces a count tick.
//  The block runs, pauses, single-steps, clears and terminates the count.
//  The count value is driven through a hex-to-7-segment decoder.
//  It sits between the board switches/keys and the display; the CountUp datapath becomes a sequenced resource.

---
 rtl/count_sequencer_pkg.sv | 53 +++++
 rtl/hex_to_seg7.sv | 13 +
 rtl/count_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count/7-segment controller: FSM state encoding,
// active-low segment patterns {g,f,e,d,c,b,a} and the digit decode helper.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // b and d use the lower-case glyphs so they are not confused with 8 and 0
  function automatic logic [6:0] seg7_of(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational hex digit to active-low 7-segment decoder.
module hex_to_seg7
  import count_sequencer_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg7_of(value);
  end

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/step/clear controller around a prescaled 4-bit counter with 7-segment output.
// Optional COUNT_DOWN_EN adds a `down` input selecting decrementing count.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int PRESCALE = 25_000_000,
  parameter int MAXCOUNT = 15,
  parameter int WRAP     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       clear,
`ifdef COUNT_DOWN_EN
  input  logic       down,
`endif
  output logic [3:0] count,
  output logic [6:0] hex,
  output logic       tick,
  output logic       busy,
  output logic       done
);

  localparam int            PW    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [3:0]    CMAX  = 4'(MAXCOUNT);

  state_t        state, state_n;
  logic [PW-1:0] pres, pres_n;
  logic [3:0]    count_n;
  logic          tick_n;
  logic          dn;
  logic [3:0]    stepped;
  logic [3:0]    term;
  logic [3:0]    reload;

`ifdef COUNT_DOWN_EN
  assign dn = down;
`else
  assign dn = 1'b0;
`endif

  // Neighbour value in the current direction; wraps both ways regardless of WRAP
  always_comb begin
    if (dn) begin
      stepped = (count == 4'd0) ? CMAX : count - 4'd1;
      term    = 4'd0;
      reload  = CMAX;
    end else begin
      stepped = (count == CMAX) ? 4'd0 : count + 4'd1;
      term    = CMAX;
      reload  = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Priority within a cycle: clear, then stop, then start, then step
  always_comb begin
    state_n = state;
    count_n = count;
    pres_n  = pres;
    tick_n  = 1'b0;
    if (clear) begin
      state_n = S_IDLE;
      count_n = 4'd0;
      pres_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stop) begin
            state_n = S_IDLE;
          end else if (start) begin
            state_n = S_RUN;
          end else if (step) begin
            count_n = stepped;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_n = S_PAUSE;
          end else if (pres == PLAST) begin
            pres_n = '0;
            tick_n = 1'b1;
            if (WRAP == 0 && count == term) begin
              state_n = S_DONE;
            end else begin
              count_n = stepped;
            end
          end else begin
            pres_n = pres + 1'b1;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state_n = S_PAUSE;
          end else if (start) begin
            state_n = S_RUN;
          end else if (step) begin
            count_n = stepped;
          end
        end
        default: begin
          // Restart from the origin of the current direction
          if (!stop && start) begin
            state_n = S_RUN;
            count_n = reload;
            pres_n  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
      pres  <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_n;
      pres  <= pres_n;
      tick  <= tick_n;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  hex_to_seg7 u_seg (
    .value (count),
    .seg   (hex)
  );

endmodule
